// File: rtl/vga_pix_out.sv
// VGA output pixel stage: pulls pixels from the FIFO and drives registered
// RGB, data-enable and polarity-adjusted syncs aligned to one enabled cycle.
module vga_pix_out #(
  parameter int PIX_DW = 16,
  parameter int UFL_CW = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              hvis_i,
  input  logic              vvis_i,
  input  logic              hsync_i,
  input  logic              vsync_i,
  input  logic              vend_i,
  input  logic              hpol_i,
  input  logic              vpol_i,
  input  logic [PIX_DW-1:0] ufl_color_i,
  input  logic              pix_valid_i,
  input  logic [PIX_DW-1:0] pix_i,
  output logic              pix_ready_o,
  output logic [PIX_DW-1:0] rgb_o,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              de_o,
  output logic              frame_done_o,
  input  logic              ufl_clr_i,
  output logic              ufl_o,
  output logic [UFL_CW-1:0] ufl_cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    ACTIVE
  } state_t;

  state_t state, state_nxt;
  logic   vis;
  logic   ufl_event;
  logic   hsync_q, vsync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Dropping the enable always returns to IDLE, so re-enable waits for vend.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (en_i) state_nxt = WAIT_FRAME;
      WAIT_FRAME: if (en_i && vend_i) state_nxt = ACTIVE;
      ACTIVE:     state_nxt = ACTIVE;
      default:    state_nxt = IDLE;
    endcase
    if (!en_i) state_nxt = IDLE;
  end

  assign vis         = hvis_i && vvis_i;
  assign pix_ready_o = (state == ACTIVE) && en_i && vis;
  assign ufl_event   = pix_ready_o && !pix_valid_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rgb_o <= '0;
      de_o  <= 1'b0;
    end else if (!en_i) begin
      rgb_o <= '0;
      de_o  <= 1'b0;
    end else begin
      de_o <= pix_ready_o;
      if (pix_ready_o) rgb_o <= pix_valid_i ? pix_i : ufl_color_i;
      else             rgb_o <= '0;
    end
  end

  // IDLE preloads the inactive level so WAIT_FRAME starts from a clean sync.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
    end else if (state == IDLE) begin
      hsync_q <= hpol_i;
      vsync_q <= vpol_i;
    end else if (en_i) begin
      hsync_q <= hsync_i ^ hpol_i;
      vsync_q <= vsync_i ^ vpol_i;
    end
  end

  assign hsync_o = (state == IDLE) ? hpol_i : hsync_q;
  assign vsync_o = (state == IDLE) ? vpol_i : vsync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) frame_done_o <= 1'b0;
    else       frame_done_o <= (state == ACTIVE) && en_i && vend_i;
  end

  // A coincident clear restarts the count at one rather than zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ufl_o     <= 1'b0;
      ufl_cnt_o <= '0;
    end else if (ufl_event) begin
      ufl_o <= 1'b1;
      if (ufl_clr_i)            ufl_cnt_o <= UFL_CW'(1);
      else if (ufl_cnt_o != '1) ufl_cnt_o <= ufl_cnt_o + UFL_CW'(1);
    end else if (ufl_clr_i) begin
      ufl_o     <= 1'b0;
      ufl_cnt_o <= '0;
    end
  end

endmodule

// File: tb/tb_vga_pix_out.sv
// Directed self-checking bench for vga_pix_out: reset, frame alignment,
// a full visible line, polarity, underflow/saturation and enable drop.
module tb_vga_pix_out;

  localparam int PIX_DW = 16;
  localparam int UFL_CW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              en, hvis, vvis, hsync, vsync, vend, hpol, vpol;
  logic [PIX_DW-1:0] ufl_color;
  logic              pix_valid;
  logic [PIX_DW-1:0] pix;
  logic              pix_ready;
  logic [PIX_DW-1:0] rgb;
  logic              hsync_out, vsync_out, de, frame_done;
  logic              ufl_clr, ufl;
  logic [UFL_CW-1:0] ufl_cnt;

  int compared = 0;
  int mismatched = 0;
  int de_count, ready_count;

  vga_pix_out #(.PIX_DW(PIX_DW), .UFL_CW(UFL_CW)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .hvis_i(hvis), .vvis_i(vvis),
    .hsync_i(hsync), .vsync_i(vsync), .vend_i(vend), .hpol_i(hpol),
    .vpol_i(vpol), .ufl_color_i(ufl_color), .pix_valid_i(pix_valid),
    .pix_i(pix), .pix_ready_o(pix_ready), .rgb_o(rgb), .hsync_o(hsync_out),
    .vsync_o(vsync_out), .de_o(de), .frame_done_o(frame_done),
    .ufl_clr_i(ufl_clr), .ufl_o(ufl), .ufl_cnt_o(ufl_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic e, input logic hv, input logic vv,
                                input logic hs, input logic vs, input logic ve,
                                input logic valid, input logic [PIX_DW-1:0] p);
    en = e; hvis = hv; vvis = vv; hsync = hs; vsync = vs; vend = ve;
    pix_valid = valid; pix = p;
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1; hpol = 1'b0; vpol = 1'b0; ufl_color = 16'hF800; ufl_clr = 1'b0;
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, '0);
    repeat (2) tick();
    check_output("rst_rgb", rgb, 0);
    check_output("rst_de", de, 0);
    check_output("rst_ufl", ufl, 0);
    check_output("rst_cnt", ufl_cnt, 0);
    check_output("rst_fdone", frame_done, 0);
    check_output("rst_hsync", hsync_out, 0);
    hpol = 1'b1; vpol = 1'b1; #1;
    check_output("rst_hsync_pol", hsync_out, 1);
    check_output("rst_vsync_pol", vsync_out, 1);
    hpol = 1'b0; vpol = 1'b0;
    rst = 1'b0;

    // Enable before the first vend: syncs flow, pixels do not
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, '0);
    tick();
    apply_stimulus(1, 1, 1, 1, 0, 0, 1, 16'h0005);
    check_output("wait_ready", pix_ready, 0);
    tick();
    check_output("wait_rgb", rgb, 0);
    check_output("wait_de", de, 0);
    check_output("wait_hsync", hsync_out, 1);
    apply_stimulus(1, 0, 1, 0, 1, 0, 1, 16'h0005);
    tick();
    check_output("wait_hsync_lat", hsync_out, 0);
    check_output("wait_vsync_lat", vsync_out, 1);

    apply_stimulus(1, 0, 1, 0, 1, 1, 1, '0);
    tick();
    check_output("enter_active_fdone", frame_done, 0);
    apply_stimulus(1, 0, 1, 0, 0, 0, 1, '0);
    check_output("active_blank_ready", pix_ready, 0);
    apply_stimulus(1, 1, 1, 0, 0, 0, 1, '0);
    check_output("active_first_ready", pix_ready, 1);

    // One full 640-pixel visible line
    de_count = 0; ready_count = 0;
    for (int i = 0; i < 640; i++) begin
      apply_stimulus(1, 1, 1, 0, 0, 0, 1, PIX_DW'(i));
      if (pix_ready) ready_count++;
      tick();
      if (de) de_count++;
      check_output("line_rgb", rgb, i);
    end
    apply_stimulus(1, 0, 1, 0, 0, 0, 1, '0);
    tick();
    check_output("line_end_de", de, 0);
    check_output("line_end_rgb", rgb, 0);
    check_output("line_de_count", de_count, 640);
    check_output("line_ready_count", ready_count, 640);

    // Underflow: three events, then a clear coincident with a fourth
    apply_stimulus(1, 1, 1, 0, 0, 0, 1, 16'h0064);
    tick();
    check_output("pre_ufl_rgb", rgb, 16'h0064);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1, 1, 1, 0, 0, 0, 0, 16'h0064);
      tick();
      check_output("ufl_rgb", rgb, 16'hF800);
    end
    check_output("ufl_flag", ufl, 1);
    check_output("ufl_cnt3", ufl_cnt, 3);
    ufl_clr = 1'b1;
    tick();
    check_output("ufl_clr_event_cnt", ufl_cnt, 1);
    check_output("ufl_clr_event_flag", ufl, 1);
    apply_stimulus(1, 1, 1, 0, 0, 0, 1, 16'h0064);
    tick();
    check_output("ufl_clr_cnt", ufl_cnt, 0);
    check_output("ufl_clr_flag", ufl, 0);
    ufl_clr = 1'b0;

    // Saturation: 2^UFL_CW + 5 events
    apply_stimulus(1, 1, 1, 0, 0, 0, 0, '0);
    repeat (255) tick();
    check_output("sat_cnt_full", ufl_cnt, 255);
    repeat (6) tick();
    check_output("sat_cnt_nowrap", ufl_cnt, 255);
    apply_stimulus(1, 0, 1, 0, 0, 0, 1, '0);
    ufl_clr = 1'b1;
    tick();
    ufl_clr = 1'b0;
    check_output("sat_clr", ufl_cnt, 0);

    // Frame done pulses once at vend while active
    apply_stimulus(1, 0, 1, 0, 1, 1, 1, '0);
    tick();
    check_output("fdone_pulse", frame_done, 1);
    apply_stimulus(1, 0, 1, 0, 0, 0, 1, '0);
    tick();
    check_output("fdone_clear", frame_done, 0);

    // Enable drop mid-line, underflow state survives
    apply_stimulus(1, 1, 1, 1, 0, 0, 0, '0);
    tick();
    apply_stimulus(1, 1, 1, 1, 0, 0, 1, 16'h1234);
    tick();
    check_output("drop_pre_rgb", rgb, 16'h1234);
    check_output("drop_pre_hsync", hsync_out, 1);
    apply_stimulus(0, 1, 1, 1, 0, 0, 1, 16'h1234);
    check_output("drop_ready", pix_ready, 0);
    tick();
    check_output("drop_rgb", rgb, 0);
    check_output("drop_de", de, 0);
    check_output("drop_hsync", hsync_out, 0);
    check_output("drop_ufl", ufl, 1);
    check_output("drop_cnt", ufl_cnt, 1);
    apply_stimulus(1, 1, 1, 1, 0, 0, 1, 16'h1234);
    check_output("reen_idle_ready", pix_ready, 0);
    tick();
    check_output("reen_wait_ready", pix_ready, 0);
    tick();
    check_output("reen_wait_rgb", rgb, 0);
    check_output("reen_wait_hsync", hsync_out, 1);
    apply_stimulus(1, 0, 1, 0, 1, 1, 1, '0);
    tick();
    check_output("reen_no_fdone", frame_done, 0);
    apply_stimulus(1, 1, 1, 0, 0, 0, 1, 16'h0ABC);
    check_output("reen_active_ready", pix_ready, 1);
    tick();
    check_output("reen_rgb", rgb, 16'h0ABC);

    // Asynchronous reset mid-frame
    rst = 1'b1; #1;
    check_output("arst_rgb", rgb, 0);
    check_output("arst_de", de, 0);
    check_output("arst_ufl", ufl, 0);

    // Active-low sync polarity
    hpol = 1'b1; vpol = 1'b1; #1;
    check_output("pol_rst_hsync", hsync_out, 1);
    check_output("pol_rst_vsync", vsync_out, 1);
    tick();
    rst = 1'b0;
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, '0);
    tick();
    check_output("pol_idle_hsync", hsync_out, 1);
    apply_stimulus(1, 0, 0, 1, 0, 0, 1, '0);
    tick();
    check_output("pol_hsync_low", hsync_out, 0);
    check_output("pol_vsync_high", vsync_out, 1);
    apply_stimulus(1, 0, 0, 0, 1, 0, 1, '0);
    tick();
    check_output("pol_vsync_low", vsync_out, 0);
    check_output("pol_hsync_back", hsync_out, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
